game_state_ctrl: RTL

Top-level game sequencer for the Pacman design. It sits downstream of the pacman and ghost location controllers and replaces the hand-written init/game FSM and the commented-out lives logic in the board top. It watches the tile coordinates and the power-pill timer for pacman/ghost collisions, and drives three things:
- the shared `play_reset` that respawns the movement and map-writer blocks;
- the lives count shown on HEX0;
- the win and game-over status.

---
 rtl/game_pkg.sv | 16 +
 rtl/ghost_collide.sv | 49 ++++
 rtl/game_state_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Pacman game sequencer.
package game_pkg;

  localparam int unsigned X_W          = 6;
  localparam int unsigned Y_W          = 5;
  localparam int unsigned GHOST_POINTS = 200;

  typedef enum logic [2:0] {
    StInit,
    StPlay,
    StDeath,
    StGameOver,
    StWin
  } game_state_t;

endpackage

// File: rtl/ghost_collide.sv
// Per-ghost collision detector: same-tile and position-swap compare plus the
// eat hold latch that limits an edible collision to a single pulse.
module ghost_collide
  import game_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           edible_i,
  input  logic [X_W-1:0] pac_x_i,
  input  logic [Y_W-1:0] pac_y_i,
  input  logic [X_W-1:0] ghost_x_i,
  input  logic [Y_W-1:0] ghost_y_i,
  output logic           hit_o,
  output logic           eat_pulse_ok_o
);

  logic [X_W-1:0] prev_pac_x_q, prev_ghost_x_q;
  logic [Y_W-1:0] prev_pac_y_q, prev_ghost_y_q;
  logic           hold_q, hold_d;
  logic           same_tile, swapped;

  always_comb begin
    same_tile = (pac_x_i == ghost_x_i) && (pac_y_i == ghost_y_i);
    // Catches pac and ghost passing through each other between two samples.
    swapped   = (pac_x_i == prev_ghost_x_q) && (pac_y_i == prev_ghost_y_q) &&
                (ghost_x_i == prev_pac_x_q) && (ghost_y_i == prev_pac_y_q);
    hit_o          = en_i && (same_tile || swapped);
    eat_pulse_ok_o = hit_o && edible_i && !hold_q;
    hold_d         = hit_o && (hold_q || eat_pulse_ok_o);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_pac_x_q   <= '0;
      prev_pac_y_q   <= '0;
      prev_ghost_x_q <= '0;
      prev_ghost_y_q <= '0;
      hold_q         <= 1'b0;
    end else begin
      prev_pac_x_q   <= pac_x_i;
      prev_pac_y_q   <= pac_y_i;
      prev_ghost_x_q <= ghost_x_i;
      prev_ghost_y_q <= ghost_y_i;
      hold_q         <= hold_d;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: start sync, INIT/PLAY/DEATH/GAME_OVER/WIN FSM, lives and
// respawn timer. Define GHOST_SCORE_EN to build the saturating ghost-eat score.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned DEATH_CYCLES = 50_000_000,
  parameter int unsigned PWR_W        = 33
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   pac_x,
  input  logic [Y_W-1:0]   pac_y,
  input  logic [X_W-1:0]   ghost1_x,
  input  logic [Y_W-1:0]   ghost1_y,
  input  logic [X_W-1:0]   ghost2_x,
  input  logic [Y_W-1:0]   ghost2_y,
  input  logic [PWR_W-1:0] power_timer,
  input  logic [8:0]       dots_left,
  output logic             play_reset,
  output logic [2:0]       lives,
  output logic [1:0]       ghost_eaten,
  output logic             game_over,
  output logic             win,
  output logic [15:0]      score
);

  localparam int unsigned TimerW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;

  game_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        lives_q, lives_d;
  logic              start_meta_q, start_sync_q, start_prev_q, start_rise;
  logic              play_reset_q, game_over_q, win_q;
  logic [1:0]        ghost_eaten_q;
  logic [1:0]        hit, eat;
  logic              edible, lethal, in_play;

  assign in_play = (state_q == StPlay);
  assign edible  = |power_timer;

  ghost_collide u_ghost1 (
    .clk_i          (CLOCK_50),
    .rst_i          (reset),
    .en_i           (in_play),
    .edible_i       (edible),
    .pac_x_i        (pac_x),
    .pac_y_i        (pac_y),
    .ghost_x_i      (ghost1_x),
    .ghost_y_i      (ghost1_y),
    .hit_o          (hit[0]),
    .eat_pulse_ok_o (eat[0])
  );

  ghost_collide u_ghost2 (
    .clk_i          (CLOCK_50),
    .rst_i          (reset),
    .en_i           (in_play),
    .edible_i       (edible),
    .pac_x_i        (pac_x),
    .pac_y_i        (pac_y),
    .ghost_x_i      (ghost2_x),
    .ghost_y_i      (ghost2_y),
    .hit_o          (hit[1]),
    .eat_pulse_ok_o (eat[1])
  );

  assign start_rise = start_sync_q && !start_prev_q;
  // Powered ghosts are never lethal, so any hit with no power is a single death.
  assign lethal     = (hit[0] || hit[1]) && !edible;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    unique case (state_q)
      StInit: begin
        if (start_rise) state_d = StPlay;
      end
      StPlay: begin
        if (lethal) begin
          state_d = StDeath;
          timer_d = TimerW'(DEATH_CYCLES - 1);
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end else if (dots_left == '0) begin
          state_d = StWin;
        end
      end
      StDeath: begin
        if (timer_q == '0) begin
          state_d = (lives_q != 3'd0) ? StPlay : StGameOver;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StGameOver, StWin: begin
        if (start_rise) state_d = StInit;
      end
      default: state_d = StInit;
    endcase
    if (state_d == StInit) lives_d = 3'(INIT_LIVES);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      start_meta_q  <= 1'b0;
      start_sync_q  <= 1'b0;
      start_prev_q  <= 1'b0;
      state_q       <= StInit;
      timer_q       <= '0;
      lives_q       <= 3'(INIT_LIVES);
      play_reset_q  <= 1'b1;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
      ghost_eaten_q <= 2'b00;
    end else begin
      start_meta_q  <= start;
      start_sync_q  <= start_meta_q;
      start_prev_q  <= start_sync_q;
      state_q       <= state_d;
      timer_q       <= timer_d;
      lives_q       <= lives_d;
      play_reset_q  <= (state_d != StPlay);
      game_over_q   <= (state_d == StGameOver);
      win_q         <= (state_d == StWin);
      ghost_eaten_q <= eat;
    end
  end

`ifdef GHOST_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [1:0]  eat_cnt;
  logic [16:0] score_sum;

  always_comb begin
    eat_cnt   = {1'b0, eat[0]} + {1'b0, eat[1]};
    score_sum = {1'b0, score_q} + 17'(GHOST_POINTS) * 17'(eat_cnt);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    if (state_d == StInit) score_d = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign play_reset  = play_reset_q;
  assign lives       = lives_q;
  assign ghost_eaten = ghost_eaten_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule
